// File: rtl/clk_div_gen.sv
//==============================================================================
// Module  : clk_div_gen
// Brief   : Multi-channel runtime-programmable divided-clock / tick generator.
//           Each channel has active and shadow configuration; shadow contents
//           are promoted only at a period boundary so outputs never glitch.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_gen #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 11,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_PERIOD_C = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_HIGH_C   = CNT_W'(DEF_HIGH);
  localparam logic [3:0]       NUM_CH_C     = 4'(NUM_CH);

  logic cfg_err_d, cfg_err_q;

  // Flag writes addressed to a channel that does not exist.
  always_comb begin
    cfg_err_d = cfg_we && ({1'b0, cfg_ch} >= NUM_CH_C);
  end

  // Register the out-of-range write pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) cfg_err_q <= 1'b0;
    else          cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period_a_q, period_a_d, high_a_q, high_a_d;
    logic [CNT_W-1:0] period_s_q, period_s_d, high_s_q, high_s_d;
    logic             en_a_q, en_a_d, en_s_q, en_s_d;
    logic             pend_q, pend_d, run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             sel, wrap, go_en;
    logic [CNT_W-1:0] go_high;

    // Next-state for counter, configuration banks and registered outputs.
    always_comb begin
      period_a_d = period_a_q;
      high_a_d   = high_a_q;
      en_a_d     = en_a_q;
      period_s_d = period_s_q;
      high_s_d   = high_s_q;
      en_s_d     = en_s_q;
      pend_d     = pend_q;
      run_d      = run_q;
      cnt_d      = cnt_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;
      go_en      = en_a_q;
      go_high    = high_a_q;
      sel        = cfg_we && (cfg_ch == 3'(i));
      wrap       = (cnt_q == period_a_q);

      if (!run_q) begin
        // No period in progress (after reset or while disabled): a write
        // takes effect immediately and an enabled channel starts at cnt 0.
        if (sel) begin
          period_a_d = cfg_period;
          high_a_d   = cfg_high;
          en_a_d     = cfg_en;
          period_s_d = cfg_period;
          high_s_d   = cfg_high;
          en_s_d     = cfg_en;
          pend_d     = 1'b0;
          go_en      = cfg_en;
          go_high    = cfg_high;
        end
        cnt_d = '0;
        if (go_en) begin
          run_d  = 1'b1;
          tick_d = 1'b1;
          clk_d  = (go_high != '0);
        end
      end else begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            period_a_d = period_s_q;
            high_a_d   = high_s_q;
            en_a_d     = en_s_q;
            pend_d     = 1'b0;
            go_en      = en_s_q;
            go_high    = high_s_q;
          end
          if (go_en) begin
            tick_d = 1'b1;
            clk_d  = (go_high != '0);
          end else begin
            run_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          clk_d = (cnt_d < high_a_q);
        end
        // A write coinciding with a wrap stays pending for the next wrap.
        if (sel) begin
          period_s_d = cfg_period;
          high_s_d   = cfg_high;
          en_s_d     = cfg_en;
          pend_d     = 1'b1;
        end
      end
    end

    // Channel state registers; reset restores defaults and drops pending writes.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        period_a_q <= DEF_PERIOD_C;
        high_a_q   <= DEF_HIGH_C;
        en_a_q     <= 1'b1;
        period_s_q <= DEF_PERIOD_C;
        high_s_q   <= DEF_HIGH_C;
        en_s_q     <= 1'b1;
        pend_q     <= 1'b0;
        run_q      <= 1'b0;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        period_a_q <= period_a_d;
        high_a_q   <= high_a_d;
        en_a_q     <= en_a_d;
        period_s_q <= period_s_d;
        high_s_q   <= high_s_d;
        en_s_q     <= en_s_d;
        pend_q     <= pend_d;
        run_q      <= run_d;
        cnt_q      <= cnt_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign cfg_pending[i] = pend_q;
    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_gen.sv
//==============================================================================
// Module  : tb_clk_div_gen
// Brief   : Directed self-checking bench for clk_div_gen (NUM_CH=2 defaults).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [10:0] cfg_period;
  logic [10:0] cfg_high;
  logic        cfg_en;
  logic        cfg_err;
  logic [1:0]  cfg_pending;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  int checks = 0;
  int errors = 0;

  clk_div_gen #(
    .NUM_CH    (2),
    .CNT_W     (11),
    .DEF_PERIOD(4),
    .DEF_HIGH  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_en     (cfg_en),
    .cfg_err    (cfg_err),
    .cfg_pending(cfg_pending),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input int per, input int hi, input logic en);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = 11'(per);
    cfg_high   = 11'(hi);
    cfg_en     = en;
  endtask

  // Step until channel 0 has no pending write; the returning sample is the
  // first cycle of the period governed by the new configuration.
  task automatic wait_applied(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      step();
      if (cfg_pending[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic ok;
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = 3'd0; cfg_period = '0; cfg_high = '0; cfg_en = 1'b0;
    step(); step(); step();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);

    // Defaults: 1,1,0,0,0 with tick on first cycle after release.
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("def_clk", 32'(clk_out), (k % 5 < 2) ? 32'd3 : 32'd0);
      chk("def_tick", 32'(tick), (k % 5 == 0) ? 32'd3 : 32'd0);
    end

    // Mid-period write on ch0 at cnt=2.
    step(); step(); step();
    wr(3'd0, 9, 5, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("mid_pend_a", 32'(cfg_pending), 32'd1);
    chk("mid_clk_a", 32'(clk_out), 32'd0);
    chk("mid_tick_a", 32'(tick), 32'd0);
    step();
    chk("mid_pend_b", 32'(cfg_pending), 32'd1);
    chk("mid_clk_b", 32'(clk_out), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) chk("mid_pend_clr", 32'(cfg_pending), 32'd0);
      chk("mid_clk", 32'(clk_out), 32'({(k % 5 < 2), (k < 5)}));
      chk("mid_tick", 32'(tick), 32'({(k % 5 == 0), (k == 0)}));
    end

    // Two writes before boundary: last one (3/3) wins.
    wr(3'd0, 7, 1, 1'b1);
    step();
    chk("two_pend_a", 32'(cfg_pending[0]), 32'd1);
    wr(3'd0, 3, 3, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("two_pend_b", 32'(cfg_pending[0]), 32'd1);
    wait_applied("two_wait");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk("two_clk", 32'(clk_out[0]), (k % 4 < 3) ? 32'd1 : 32'd0);
      chk("two_tick", 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // high = 0 -> constant low.
    wr(3'd0, 4, 0, 1'b1);
    step();
    cfg_we = 1'b0;
    wait_applied("h0_wait");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      chk("h0_clk", 32'(clk_out[0]), 32'd0);
      chk("h0_tick", 32'(tick[0]), (k == 0) ? 32'd1 : 32'd0);
    end

    // high > period -> constant high.
    wr(3'd0, 4, 20, 1'b1);
    step();
    cfg_we = 1'b0;
    wait_applied("hbig_wait");
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      chk("hbig_clk", 32'(clk_out[0]), 32'd1);
      chk("hbig_tick", 32'(tick[0]), (k % 5 == 0) ? 32'd1 : 32'd0);
    end

    // period = 0, high = 1 -> high and tick every cycle.
    wr(3'd0, 0, 1, 1'b1);
    step();
    cfg_we = 1'b0;
    wait_applied("p0_wait");
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      chk("p0_clk", 32'(clk_out[0]), 32'd1);
      chk("p0_tick", 32'(tick[0]), 32'd1);
    end

    // Disable ch1 at cnt=1.
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (tick[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dis_find", 32'(ok), 32'd1);
    step();
    wr(3'd1, 4, 2, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("dis_pend_a", 32'(cfg_pending), 32'd2);
    chk("dis_clk_a", 32'(clk_out[1]), 32'd0);
    step();
    chk("dis_pend_b", 32'(cfg_pending), 32'd2);
    step();
    chk("dis_pend_c", 32'(cfg_pending), 32'd2);
    chk("dis_tick_c", 32'(tick[1]), 32'd0);
    step();
    chk("dis_pend_d", 32'(cfg_pending), 32'd0);
    chk("dis_tick_d", 32'(tick[1]), 32'd0);
    chk("dis_clk_d", 32'(clk_out[1]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("dis_clk", 32'(clk_out), 32'd1);
      chk("dis_tick", 32'(tick), 32'd1);
    end

    // Re-enable ch1: starts next cycle at cnt=0 with tick.
    wr(3'd1, 4, 2, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("ren_tick", 32'(tick), 32'd3);
    chk("ren_clk", 32'(clk_out), 32'd3);
    chk("ren_pend", 32'(cfg_pending), 32'd0);
    step();
    chk("ren_clk1", 32'(clk_out), 32'd3);
    chk("ren_tick1", 32'(tick), 32'd1);
    step();
    chk("ren_clk2", 32'(clk_out), 32'd1);

    // Out-of-range channel.
    wr(3'd5, 9, 9, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("err_pulse", 32'(cfg_err), 32'd1);
    chk("err_pend", 32'(cfg_pending), 32'd0);
    chk("err_clk", 32'(clk_out), 32'd1);
    chk("err_tick", 32'(tick), 32'd1);
    step();
    chk("err_clear", 32'(cfg_err), 32'd0);
    step();
    chk("err_ch1_tick", 32'(tick), 32'd3);
    chk("err_ch1_clk", 32'(clk_out), 32'd3);

    // Reset with a write pending.
    wr(3'd0, 9, 5, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("rp_pend", 32'(cfg_pending), 32'd1);
    reset_n = 1'b0;
    step();
    chk("rp_pend_clr", 32'(cfg_pending), 32'd0);
    chk("rp_clk", 32'(clk_out), 32'd0);
    chk("rp_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rp_def_clk", 32'(clk_out), (k % 5 < 2) ? 32'd3 : 32'd0);
      chk("rp_def_tick", 32'(tick), (k % 5 == 0) ? 32'd3 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
